alarm_sequencer: RTL
====================

ALARM_SEQUENCER -- requirements
Module: alarm_sequencer

Interface
REQ-001 SHALL have parameter EVAC_MIN, default 2: count of latched rooms at or above which evacuation code is signalled (legal 1..16).
REQ-002 SHALL have port clk  in  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-004 SHALL have port room  in  16  per-room alarm level (bit i = room i), synchronous to clk.
REQ-005 SHALL have port dwell  in  8  announce duration in cycles; 0 treated as 1.
REQ-006 SHALL have port ack  in  1  operator acknowledge, one-cycle pulse or level.
REQ-007 SHALL have port led  out  16  latched alarm per room.
REQ-008 SHALL have port grant  out  16  one-hot grant of the shared siren/announcer to one room, zero when none.
REQ-009 SHALL have port cur_room  out  4  index of room last or currently granted.
REQ-010 SHALL have port sig  out  2  siren code: 00 off, 01 pre-alarm, 10 announce, 11 evacuate.
REQ-011 SHALL have port busy  out  1  high in every state except IDLE.

Function
REQ-012 SHALL latch: led_next = (led AND NOT ack-mask) OR room; a room asserted in the same cycle as ack stays latched.
REQ-013 SHALL implement FSM IDLE(00), SCAN(01), ANNOUNCE(10), GAP(11).
REQ-014 IDLE: SHALL go to SCAN when led != 0.
REQ-015 SCAN (one cycle): SHALL pick the first latched room searching from ptr+1 upward modulo 16, set grant one-hot and cur_room to it, load timer with max(dwell,1), go to ANNOUNCE.
REQ-016 ANNOUNCE: SHALL hold grant, decrement timer each cycle; at timer==1 SHALL go to GAP and set ptr = cur_room.
REQ-017 GAP: SHALL drive grant = 0 for exactly one cycle, then go to SCAN.
REQ-018 From any state, SHALL go to IDLE with grant = 0 at the next edge when led_next == 0 (all acknowledged, no room active).
REQ-019 ack with led_next != 0 during ANNOUNCE SHALL NOT shorten the current announcement, even if the granted room was cleared.
REQ-020 dwell SHALL be sampled only in SCAN; changes during ANNOUNCE have no effect.
REQ-021 sig SHALL be 11 when state != IDLE and popcount(led) >= EVAC_MIN; else 10 in ANNOUNCE, 01 in SCAN/GAP, 00 in IDLE.
REQ-022 All outputs SHALL be registers or decodes of registers only; no combinational path from room/ack/dwell to outputs.
REQ-023 Latency: room bit rising before edge t SHALL give led at t, SCAN at t+1, grant at t+2.
REQ-024 Round-robin SHALL be fair: with k latched rooms, each is granted once per k announcements.
REQ-025 At most one grant bit SHALL be high in any cycle.

Reset
REQ-026 On reset low, asynchronously: state=IDLE, led=0, grant=0, cur_room=0, sig=00, busy=0, timer=0, ptr=15 (room 0 searched first).
REQ-027 Reset asserted mid-ANNOUNCE SHALL drop grant and sig immediately, without waiting for a clock edge.
REQ-028 Release SHALL be clean; first state update at the first rising edge after release.

Structure
REQ-029 Shared package fire_alarm_pkg SHALL hold N_ROOMS=16, state encodings, and sig codes SIG_OFF/SIG_PRE/SIG_ANN/SIG_EVAC.
REQ-030 Round-robin search SHALL be a sub-module rr_pick (inputs req[15:0], ptr[3:0]; outputs idx[3:0], found) that is purely combinational.
REQ-031 Timer SHALL be 8 bits; popcount for the EVAC comparison SHALL be 5 bits.

Verification
REQ-032 Single room: room=0x0010 one cycle, dwell=3 -> led=0x0010; grant=0x0010 for 3 cycles from t+2; sig=10; GAP; repeats until ack.
REQ-033 Round-robin: room=0x8001 held, dwell=2 -> grant order 0x0001, 0x8000, 0x0001; sig=11 throughout (EVAC_MIN=2).
REQ-034 Ack clear: single room latched, room low, ack pulse mid-ANNOUNCE -> next edge IDLE, grant=0, led=0, sig=00, busy=0.
REQ-035 Ack vs active room: room=0x0004 held high, ack pulsed -> led stays 0x0004, sequence continues uninterrupted.
REQ-036 dwell=0 -> grant lasts exactly 1 cycle, then a 1-cycle GAP.
REQ-037 Async reset mid-ANNOUNCE, between clock edges -> grant=0, led=0, sig=00 immediately; after release and room=0x0002, first grant goes to 0x0002.

Source files
------------

// File: rtl/fire_alarm_pkg.sv
// Shared types and constants for the fire alarm sequencer.
// Room count, FSM encodings, siren codes and small helpers.
package fire_alarm_pkg;

    localparam int N_ROOMS = 16;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_SCAN     = 2'b01,
        ST_ANNOUNCE = 2'b10,
        ST_GAP      = 2'b11
    } state_t;

    localparam logic [1:0] SIG_OFF  = 2'b00;
    localparam logic [1:0] SIG_PRE  = 2'b01;
    localparam logic [1:0] SIG_ANN  = 2'b10;
    localparam logic [1:0] SIG_EVAC = 2'b11;

    function automatic logic [4:0] popcount16(input logic [15:0] v);
        logic [4:0] c;
        c = '0;
        for (int i = 0; i < N_ROOMS; i++) begin
            c = c + {4'b0000, v[i]};
        end
        return c;
    endfunction

    function automatic logic [15:0] onehot16(input logic [3:0] idx);
        return 16'b1 << idx;
    endfunction

endpackage

// File: rtl/alarm_sequencer_if.sv
// Operator/room side bundle of the alarm sequencer.
// master drives room/dwell/ack, slave (the sequencer) drives the status.
interface alarm_sequencer_if;

    logic [15:0] room;
    logic [7:0]  dwell;
    logic        ack;
    logic [15:0] led;
    logic [15:0] grant;
    logic [3:0]  cur_room;
    logic [1:0]  sig;
    logic        busy;

    modport master (
        output room,
        output dwell,
        output ack,
        input  led,
        input  grant,
        input  cur_room,
        input  sig,
        input  busy
    );

    modport slave (
        input  room,
        input  dwell,
        input  ack,
        output led,
        output grant,
        output cur_room,
        output sig,
        output busy
    );

endinterface

// File: rtl/alarm_sequencer_rr_pick.sv
// Round-robin picker: first set request strictly after ptr,
// wrapping modulo 16, ptr itself considered last.
module rr_pick (
    input  logic [15:0] req,
    input  logic [3:0]  ptr,
    output logic [3:0]  idx,
    output logic        found
);

    logic [3:0] w_j;

    // Walk ptr+1 .. ptr+16 and keep the first hit
    always_comb begin
        found = 1'b0;
        idx   = '0;
        w_j   = ptr;
        for (int i = 1; i <= 16; i++) begin
            w_j = ptr + 4'(i);
            if (!found && req[w_j]) begin
                found = 1'b1;
                idx   = w_j;
            end
        end
    end

endmodule

// File: rtl/alarm_sequencer.sv
// Fire alarm sequencer: latches room alarms and time-shares the
// siren/announcer among latched rooms in round-robin order.
module alarm_sequencer
    import fire_alarm_pkg::*;
#(
    parameter int EVAC_MIN = 2
) (
    input  logic clk,
    input  logic reset,
    alarm_sequencer_if.slave bus
);

    localparam logic [4:0] EVAC_THR = 5'(EVAC_MIN);

    state_t      r_state;
    logic [15:0] r_led;
    logic [15:0] r_grant;
    logic [3:0]  r_cur;
    logic [3:0]  r_ptr;
    logic [7:0]  r_timer;
    logic [1:0]  r_sig;
    logic        r_busy;

    logic [15:0] w_led_next;
    logic [7:0]  w_dwell;
    logic        w_evac;
    logic [3:0]  w_idx;
    logic        w_found;

    // ack clears every latch, but a room still active re-latches
    assign w_led_next = bus.ack ? bus.room : (r_led | bus.room);
    assign w_dwell    = (bus.dwell == 8'd0) ? 8'd1 : bus.dwell;
    assign w_evac     = popcount16(w_led_next) >= EVAC_THR;

    rr_pick u_pick (
        .req   (r_led),
        .ptr   (r_ptr),
        .idx   (w_idx),
        .found (w_found)
    );

    // Latch alarms and run the scan/announce/gap cycle;
    // sig and busy are computed for the state being entered
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_led   <= '0;
            r_grant <= '0;
            r_cur   <= '0;
            r_ptr   <= 4'd15;
            r_timer <= '0;
            r_sig   <= SIG_OFF;
            r_busy  <= 1'b0;
        end else begin
            r_led <= w_led_next;
            if (w_led_next == '0) begin
                r_state <= ST_IDLE;
                r_grant <= '0;
                r_timer <= '0;
                r_sig   <= SIG_OFF;
                r_busy  <= 1'b0;
            end else begin
                unique case (r_state)
                    ST_IDLE: begin
                        if (r_led != '0) begin
                            r_state <= ST_SCAN;
                            r_busy  <= 1'b1;
                            r_sig   <= w_evac ? SIG_EVAC : SIG_PRE;
                        end else begin
                            r_busy  <= 1'b0;
                            r_sig   <= SIG_OFF;
                        end
                    end
                    ST_SCAN: begin
                        if (w_found) begin
                            r_state <= ST_ANNOUNCE;
                            r_grant <= onehot16(w_idx);
                            r_cur   <= w_idx;
                            r_timer <= w_dwell;
                            r_sig   <= w_evac ? SIG_EVAC : SIG_ANN;
                        end else begin
                            r_state <= ST_IDLE;
                            r_grant <= '0;
                            r_busy  <= 1'b0;
                            r_sig   <= SIG_OFF;
                        end
                    end
                    ST_ANNOUNCE: begin
                        if (r_timer <= 8'd1) begin
                            r_state <= ST_GAP;
                            r_grant <= '0;
                            r_ptr   <= r_cur;
                            r_timer <= '0;
                            r_sig   <= w_evac ? SIG_EVAC : SIG_PRE;
                        end else begin
                            r_timer <= r_timer - 8'd1;
                            r_sig   <= w_evac ? SIG_EVAC : SIG_ANN;
                        end
                    end
                    ST_GAP: begin
                        r_state <= ST_SCAN;
                        r_sig   <= w_evac ? SIG_EVAC : SIG_PRE;
                    end
                endcase
            end
        end
    end

    assign bus.led      = r_led;
    assign bus.grant    = r_grant;
    assign bus.cur_room = r_cur;
    assign bus.sig      = r_sig;
    assign bus.busy     = r_busy;

endmodule
